axil_sram_responder: RTL and testbench

Single-port AXI4-Lite-style memory responder: the subordinate end of the load/store bus driven by the core's LSU. It holds a word-organised SRAM model, accepts one read or one write transaction at a time, inserts a fixed programmable access latency, and returns data or a write response with OKAY/SLVERR status. It sits between the LSU/IFU bus masters (through the arbiter) and simulation memory.

---
 rtl/axil_sram_responder_if.sv | 34 +++
 rtl/axil_sram_responder.sv | 142 ++++++++++++++
 tb/tb_axil_sram_responder.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_sram_responder_if.sv
// axil_sram_responder_if
//   AXI4-Lite-style load/store bus between a bus master (LSU/IFU via the
//   arbiter) and the SRAM responder. Five channels: AR, R, AW, W, B.
//   master modport: drives addresses, write data, valids and response readies.
//   slave modport : drives address/data readies, read data and responses.
interface axil_sram_responder_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axil_sram_responder.sv
// axil_sram_responder
//   Single-port word-organised SRAM behind an AXI4-Lite-style subordinate
//   interface. One read or one write in flight; fixed LATENCY idle cycles
//   before the response; out-of-range accesses answer SLVERR.
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - slave end of the AR/R/AW/W/B bus
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for AR (priority) or AW
// RD_WAIT | counting down latency; memory sampled into rdata at 0
// RD_RESP | rvalid high, holding rdata/rresp until rready
// WR_DATA | address accepted, waiting for W beat
// WR_WAIT | write committed, counting down latency
// WR_RESP | bvalid high, holding bresp until bready
module axil_sram_responder #(
    parameter logic [31:0] BASE        = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    axil_sram_responder_if.slave        bus
);
    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN        = 32'(DEPTH_WORDS * 4);
    localparam logic [7:0]  LAT         = 8'(LATENCY);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_DATA = 3'd3,
        WR_WAIT = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [7:0]  cnt_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          ar_hs, aw_hs, w_hs;
    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;

    assign ar_hs = bus.arvalid && bus.arready;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;

    // Subtracting first keeps the range test correct even when BASE + span
    // would wrap past 2^32.
    assign off      = addr_q - BASE;
    assign in_range = off < SPAN;
    assign idx      = off[AW+1:2];

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Both paths always pass through a wait state, even with LATENCY 0: the
    // memory is sampled one edge after the address/data beat is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ar_hs)      state_nxt = RD_WAIT;
                else if (aw_hs) state_nxt = WR_DATA;
            end
            RD_WAIT: if (cnt_q == 8'd0) state_nxt = RD_RESP;
            RD_RESP: if (bus.rready)    state_nxt = IDLE;
            WR_DATA: if (w_hs)          state_nxt = WR_WAIT;
            WR_WAIT: if (cnt_q == 8'd0) state_nxt = WR_RESP;
            WR_RESP: if (bus.bready)    state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.arready = (state == IDLE);
        bus.awready = (state == IDLE) && !bus.arvalid;
        bus.wready  = (state == WR_DATA);
        bus.rvalid  = (state == RD_RESP);
        bus.bvalid  = (state == WR_RESP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q    <= 32'd0;
            cnt_q     <= 8'd0;
            bus.rdata <= 32'd0;
            bus.rresp <= RESP_OKAY;
            bus.bresp <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        addr_q <= bus.araddr;
                        cnt_q  <= LAT;
                    end else if (aw_hs) begin
                        addr_q <= bus.awaddr;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        bus.rdata <= in_range ? mem[idx] : 32'd0;
                        bus.rresp <= in_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        cnt_q     <= LAT;
                        bus.bresp <= in_range ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                WR_WAIT: begin
                    if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Memory has no reset; a write is committed on the W beat itself, so a
    // later reset cannot undo it.
    always_ff @(posedge clock) begin
        if (!reset && w_hs && in_range) begin
            if (bus.wstrb[0]) mem[idx][7:0]   <= bus.wdata[7:0];
            if (bus.wstrb[1]) mem[idx][15:8]  <= bus.wdata[15:8];
            if (bus.wstrb[2]) mem[idx][23:16] <= bus.wdata[23:16];
            if (bus.wstrb[3]) mem[idx][31:24] <= bus.wdata[31:24];
        end
    end
endmodule

// File: tb/tb_axil_sram_responder.sv
// tb_axil_sram_responder
//   Two responders (LATENCY 1 and LATENCY 0) share one set of stimulus
//   variables; sel routes valids/readies to one of them and picks which
//   outputs are observed. A per-instance word array is the reference memory.
module tb_axil_sram_responder;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    axil_sram_responder_if b1();
    axil_sram_responder_if b0();

    axil_sram_responder #(.BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .bus(b1.slave));
    axil_sram_responder #(.BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clock(clock), .reset(reset), .bus(b0.slave));

    logic        sel = 1'b1;
    int          cur_lat = 1;
    logic [31:0] d_araddr = '0, d_awaddr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_arvalid = 0, d_rready = 0, d_awvalid = 0, d_wvalid = 0, d_bready = 0;

    assign b1.araddr  = d_araddr;
    assign b1.awaddr  = d_awaddr;
    assign b1.wdata   = d_wdata;
    assign b1.wstrb   = d_wstrb;
    assign b1.arvalid = d_arvalid && sel;
    assign b1.rready  = d_rready && sel;
    assign b1.awvalid = d_awvalid && sel;
    assign b1.wvalid  = d_wvalid && sel;
    assign b1.bready  = d_bready && sel;
    assign b0.araddr  = d_araddr;
    assign b0.awaddr  = d_awaddr;
    assign b0.wdata   = d_wdata;
    assign b0.wstrb   = d_wstrb;
    assign b0.arvalid = d_arvalid && !sel;
    assign b0.rready  = d_rready && !sel;
    assign b0.awvalid = d_awvalid && !sel;
    assign b0.wvalid  = d_wvalid && !sel;
    assign b0.bready  = d_bready && !sel;

    logic        o_arready, o_rvalid, o_awready, o_wready, o_bvalid;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp, o_bresp;
    assign o_arready = sel ? b1.arready : b0.arready;
    assign o_rvalid  = sel ? b1.rvalid  : b0.rvalid;
    assign o_rdata   = sel ? b1.rdata   : b0.rdata;
    assign o_rresp   = sel ? b1.rresp   : b0.rresp;
    assign o_awready = sel ? b1.awready : b0.awready;
    assign o_wready  = sel ? b1.wready  : b0.wready;
    assign o_bvalid  = sel ? b1.bvalid  : b0.bvalid;
    assign o_bresp   = sel ? b1.bresp   : b0.bresp;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] last_rdata;
    logic [31:0] ref_mem [2][DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_in(input logic [31:0] a);
        longint unsigned la, lb;
        la = 64'(a);
        lb = 64'(BASE);
        return (la >= lb) && (la < lb + 64'(4 * DEPTH));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic do_read(input logic [31:0] a, input int hold);
        logic [31:0] ed;
        logic [1:0]  er;
        int          j;
        int          s;
        s  = sel ? 1 : 0;
        ed = m_in(a) ? ref_mem[s][m_idx(a)] : 32'd0;
        er = m_in(a) ? 2'b00 : 2'b10;
        d_araddr = a; d_arvalid = 1'b1; d_rready = (hold == 0);
        j = 0;
        while (!o_arready && j < 100) begin @(negedge clock); j++; end
        @(negedge clock);
        d_arvalid = 1'b0;
        j = 0;
        while (!o_rvalid && j < 300) begin @(negedge clock); j++; end
        check("rd_latency", 32'(j), 32'(cur_lat + 1));
        check("rd_data", o_rdata, ed);
        check("rd_resp", 32'(o_rresp), 32'(er));
        last_rdata = o_rdata;
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clock);
                check("rd_hold_valid", 32'(o_rvalid), 32'd1);
                check("rd_hold_data", o_rdata, ed);
            end
            d_rready = 1'b1;
        end
        @(negedge clock);
        d_rready = 1'b0;
        check("rd_done_rvalid", 32'(o_rvalid), 32'd0);
        check("rd_done_arready", 32'(o_arready), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] data, input logic [3:0] strb,
                            input int gap, input int hold);
        logic [1:0] er;
        int         j;
        int         s;
        s  = sel ? 1 : 0;
        er = m_in(a) ? 2'b00 : 2'b10;
        if (m_in(a)) begin
            for (int l = 0; l < 4; l++)
                if (strb[l]) ref_mem[s][m_idx(a)][8*l +: 8] = data[8*l +: 8];
        end
        d_awaddr = a; d_awvalid = 1'b1;
        j = 0;
        while (!o_awready && j < 100) begin @(negedge clock); j++; end
        @(negedge clock);
        d_awvalid = 1'b0;
        check("wr_wready", 32'(o_wready), 32'd1);
        repeat (gap) @(negedge clock);
        d_wdata = data; d_wstrb = strb; d_wvalid = 1'b1; d_bready = (hold == 0);
        @(negedge clock);
        d_wvalid = 1'b0;
        j = 0;
        while (!o_bvalid && j < 300) begin @(negedge clock); j++; end
        check("wr_latency", 32'(j), 32'(cur_lat + 1));
        check("wr_resp", 32'(o_bresp), 32'(er));
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clock);
                check("wr_hold_valid", 32'(o_bvalid), 32'd1);
                check("wr_hold_resp", 32'(o_bresp), 32'(er));
            end
            d_bready = 1'b1;
        end
        @(negedge clock);
        d_bready = 1'b0;
        check("wr_done_bvalid", 32'(o_bvalid), 32'd0);
        check("wr_done_awready", 32'(o_awready), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        int w;
        k = $urandom_range(0, 9);
        if (k < 7) begin
            w = $urandom_range(0, 16);
            if (w == 16) w = DEPTH - 1;
            return BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
        end
        case (k)
            7:       return 32'h9000_0000;
            8:       return BASE + 32'(4 * DEPTH);
            default: return $urandom() & 32'h7FFF_FFFC;
        endcase
    endfunction

    task automatic run_random();
        if ($urandom_range(0, 1) == 1)
            do_read(rand_addr(), $urandom_range(0, 3));
        else
            do_write(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 2), $urandom_range(0, 3));
    endtask

    initial begin
        logic [31:0] ed;
        bit          blocked;
        int          j;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int s = 1; s >= 0; s--) begin
            sel = s[0];
            #1;
            check("rst_arready", 32'(o_arready), 32'd1);
            check("rst_awready", 32'(o_awready), 32'd1);
            check("rst_wready", 32'(o_wready), 32'd0);
            check("rst_rvalid", 32'(o_rvalid), 32'd0);
            check("rst_bvalid", 32'(o_bvalid), 32'd0);
            check("rst_rdata", o_rdata, 32'd0);
            check("rst_rresp", 32'(o_rresp), 32'd0);
            check("rst_bresp", 32'(o_bresp), 32'd0);
            d_arvalid = 1'b1;
            #1;
            check("rst_awready_arvalid", 32'(o_awready), 32'd0);
            d_arvalid = 1'b0;
        end
        sel = 1'b1;
        @(negedge clock);

        // Preload words 0..15 and the top word of both instances.
        for (int s = 1; s >= 0; s--) begin
            sel = s[0];
            cur_lat = s;
            for (int w = 0; w <= 16; w++)
                do_write(BASE + 32'(((w == 16) ? DEPTH - 1 : w) * 4), $urandom(), 4'hF, 0, 0);
        end
        sel = 1'b1;
        cur_lat = 1;

        do_write(BASE, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_read(BASE, 0);
        check("tp_word0", last_rdata, 32'hDEAD_BEEF);

        do_write(BASE + 4, 32'hAAAA_AAAA, 4'hF, 0, 0);
        do_write(BASE + 4, 32'h1122_3344, 4'b0001, 0, 0);
        do_read(BASE + 4, 0);
        check("tp_strb_0001", last_rdata, 32'hAAAA_AA44);
        do_write(BASE + 4, 32'hAAAA_AAAA, 4'hF, 0, 0);
        do_write(BASE + 4, 32'h1122_3344, 4'b0011, 0, 0);
        do_read(BASE + 4, 0);
        check("tp_strb_0011", last_rdata, 32'hAAAA_3344);
        do_write(BASE + 4, 32'hFFFF_FFFF, 4'b0000, 0, 0);
        do_read(BASE + 4, 0);
        check("tp_strb_0000", last_rdata, 32'hAAAA_3344);

        do_read(32'h0000_0000, 0);
        do_write(32'h9000_0000, 32'h5555_5555, 4'hF, 0, 0);
        do_write(BASE + 32'(4 * DEPTH), 32'h1234_5678, 4'hF, 1, 0);
        do_write(BASE - 4, 32'h8765_4321, 4'hF, 0, 0);
        do_read(BASE, 0);
        check("tp_oor_unchanged", last_rdata, 32'hDEAD_BEEF);

        // W beat with no AW in flight must be ignored.
        d_wdata = 32'h0BAD_0BAD; d_wstrb = 4'hF; d_wvalid = 1'b1;
        #1;
        check("idle_wready", 32'(o_wready), 32'd0);
        repeat (3) @(negedge clock);
        check("idle_w_bvalid", 32'(o_bvalid), 32'd0);
        d_wvalid = 1'b0;
        do_read(BASE + 4, 0);

        // Simultaneous AR and AW: read first, AW held off until R completes.
        ed = ref_mem[1][0];
        d_araddr = BASE; d_arvalid = 1'b1;
        d_awaddr = BASE + 20; d_awvalid = 1'b1; d_rready = 1'b1;
        #1;
        check("arb_arready", 32'(o_arready), 32'd1);
        check("arb_awready", 32'(o_awready), 32'd0);
        @(negedge clock);
        d_arvalid = 1'b0;
        blocked = 1'b1;
        j = 0;
        while (!o_rvalid && j < 300) begin
            if (o_awready) blocked = 1'b0;
            @(negedge clock);
            j++;
        end
        if (o_awready) blocked = 1'b0;
        check("arb_aw_blocked", 32'(blocked), 32'd1);
        check("arb_rdata", o_rdata, ed);
        @(negedge clock);
        d_rready = 1'b0;
        check("arb_r_done", 32'(o_rvalid), 32'd0);
        check("arb_awready_after", 32'(o_awready), 32'd1);
        do_write(BASE + 20, 32'hC0FF_EE00, 4'hF, 0, 0);
        do_read(BASE + 20, 0);

        do_read(BASE, 5);
        do_write(BASE + 8, 32'h0123_4567, 4'hF, 2, 5);
        do_read(BASE + 8, 0);

        // Reset while waiting for W: write dropped, outputs back to reset.
        d_awaddr = BASE + 12; d_awvalid = 1'b1;
        @(negedge clock);
        d_awvalid = 1'b0;
        check("rst_mid_wready", 32'(o_wready), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_rvalid", 32'(o_rvalid), 32'd0);
        check("rst_mid_bvalid", 32'(o_bvalid), 32'd0);
        check("rst_mid_wready0", 32'(o_wready), 32'd0);
        check("rst_mid_arready", 32'(o_arready), 32'd1);
        reset = 1'b0;
        d_wdata = 32'hFFFF_0000; d_wstrb = 4'hF; d_wvalid = 1'b1;
        @(negedge clock);
        d_wvalid = 1'b0;
        do_read(BASE + 12, 0);

        for (int it = 0; it < 40; it++) run_random();

        sel = 1'b0;
        cur_lat = 0;
        do_read(BASE, 0);
        do_write(BASE + 4, 32'h1122_3344, 4'b0011, 0, 2);
        do_read(BASE + 4, 3);
        do_read(32'h0000_0000, 0);
        for (int it = 0; it < 25; it++) run_random();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
